// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - two-into-one sram-like port arbiter with in-order response routing
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [70:0] inst_cmd,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [70:0] data_cmd,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic [70:0] mem_cmd,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        proto_err
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_INST = 2'd1,
        HOLD_DATA = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            gnt_inst;
    logic            gnt_data;
    logic            gnt_req;
    logic            full;
    logic            push;
    logic            pop;
    logic            starved;
    logic [3:0]      starve_cnt;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [1:0]      tag_mem [MAX_OUTSTANDING];
    logic [1:0]      head_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_nx = gnt_data ? HOLD_DATA : HOLD_INST;
                end
            end
            HOLD_INST: begin
                if (mem_addr_ok || !inst_req) begin
                    state_nx = IDLE;
                end
            end
            HOLD_DATA: begin
                if (mem_addr_ok || !data_req) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant decode: a held grant is sticky; otherwise starvation beats data priority.
    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        case (state)
            HOLD_INST: gnt_inst = 1'b1;
            HOLD_DATA: gnt_data = 1'b1;
            default: begin
                if (inst_req && starved) begin
                    gnt_inst = 1'b1;
                end else if (data_req) begin
                    gnt_data = 1'b1;
                end else if (inst_req) begin
                    gnt_inst = 1'b1;
                end
            end
        endcase
    end

    assign starved      = (starve_cnt >= 4'(STARVE_LIMIT));
    assign gnt_req      = (gnt_inst & inst_req) | (gnt_data & data_req);
    assign full         = (count == CW'(MAX_OUTSTANDING));
    assign mem_req      = gnt_req && !full;
    assign mem_cmd      = gnt_data ? data_cmd : inst_cmd;
    assign push         = mem_req && mem_addr_ok;
    assign pop          = mem_data_ok && (count != '0);
    assign inst_addr_ok = push && gnt_inst;
    assign data_addr_ok = push && gnt_data;
    assign head_tag     = tag_mem[rd_ptr];
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Tag is {owner, wr}; owner=1 routes the response to the data side.
    always_comb begin
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        if (pop) begin
            case (head_tag)
                2'b10, 2'b11: data_data_ok = 1'b1;
                default:      inst_data_ok = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= {gnt_data, mem_cmd[70]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            proto_err  <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (mem_data_ok && (count == '0)) begin
                proto_err <= 1'b1;
            end
            if (!inst_req || inst_addr_ok) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Shares one downstream sram-like memory port between the core's instruction-fetch and data-access sram-like interfaces. It arbitrates new requests with data priority plus an inst anti-starvation override, and holds the grant until the downstream accepts the address. An in-order owner FIFO records each accepted transaction so that every downstream data_ok and rdata is returned to the requester that issued it. The block sits between cpu_core and the single memory/bridge port at the top level.

Parameters:
MAX_OUTSTANDING, 2, owner-FIFO depth: max accepted-but-unanswered transactions (power of 2, >=2)
STARVE_LIMIT, 8, cycles inst may wait with req high before it overrides data priority (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_req  in  1  inst request valid
inst_cmd  in  71  {wr[70], size[69:68], wstrb[67:64], addr[63:32], wdata[31:0]}
inst_addr_ok  out  1  inst request accepted downstream this cycle
inst_data_ok  out  1  inst response valid this cycle
inst_rdata  out  32  inst read data, valid with inst_data_ok
data_req  in  1  data request valid
data_cmd  in  71  same packing as inst_cmd
data_addr_ok  out  1  data request accepted downstream this cycle
data_data_ok  out  1  data response valid this cycle
data_rdata  out  32  data read data, valid with data_data_ok
mem_req  out  1  downstream request valid
mem_cmd  out  71  granted requester's cmd, same packing
mem_addr_ok  in  1  downstream accepts mem_req this cycle
mem_data_ok  in  1  downstream response, strictly in acceptance order (reads and writes)
mem_rdata  in  32  downstream read data
proto_err  out  1  sticky: mem_data_ok seen with owner FIFO empty

Behaviour:
- Reset (async, active-high) clears: state->IDLE, FIFO pointers/count->0, starve_cnt->0, proto_err->0. With no inputs active, all *_addr_ok, *_data_ok and mem_req read 0 during and after reset. mem_cmd and *_rdata are don't-care when their valids are low.
- FSM states:
  - IDLE: choose the grant combinationally. Inst wins if inst_req && starve_cnt>=STARVE_LIMIT. Otherwise data wins if data_req. Otherwise inst wins if inst_req.
  - HOLD_INST / HOLD_DATA: grant is locked to that side.
- full = (count==MAX_OUTSTANDING).
- mem_req = granted side's req && !full. mem_cmd = granted side's cmd (zero-cycle pass-through).
- Transitions:
  - IDLE with mem_req && !mem_addr_ok -> HOLD_<granted>.
  - HOLD_x with mem_addr_ok -> IDLE.
  - HOLD_x with x_req dropped (upstream cancel) -> IDLE next cycle; no push.
  - A grant is never switched while in HOLD_x, even if the other side requests.
- <granted>_addr_ok = mem_req && mem_addr_ok. The non-granted side's addr_ok is always 0.
- Push: on mem_req && mem_addr_ok, write tag {owner, wr} into the FIFO.
- Full-FIFO push rule: when full, the push is blocked even if a pop occurs in the same cycle (mem_req=0 that cycle). Push and pop in the same cycle when not full leave count unchanged.
- Pop: on mem_data_ok && count!=0, pop the head. head.owner selects which *_data_ok pulses (combinational). *_rdata = mem_rdata for both sides. Write responses also pulse data_ok.
- mem_data_ok with count==0: no upstream data_ok, set proto_err=1 (sticky until reset), count stays 0.
- starve_cnt (4 bits, saturating at 15):
  - +1 each cycle inst_req && !inst_addr_ok.
  - Cleared when inst_addr_ok or !inst_req.
- FIFO pointers wrap modulo MAX_OUTSTANDING. count ranges 0..MAX_OUTSTANDING.
- Latency: addr_ok and data_ok paths are 0 cycles (combinational). No added pipeline stage.

Test Plan:
1. Inst only: inst_req, addr 0x1C000000, wr=0; mem_addr_ok same cycle; mem_data_ok 2 cycles later with rdata 0x02800C0C -> inst_addr_ok=1 that cycle; inst_data_ok=1 with inst_rdata=0x02800C0C; data_data_ok stays 0.
2. Simultaneous inst_req and data_req (data addr 0x1C008000), mem_addr_ok=1 every cycle -> cycle0 mem_cmd[63:32]=0x1C008000 with data_addr_ok; cycle1 inst granted with inst_addr_ok.
3. Ordering: inst read accepted, then data write (wstrb 0xF) accepted, two mem_data_ok pulses -> first pulses inst_data_ok only, second pulses data_data_ok only.
4. Full: two requests accepted, no data_ok, data_req held -> mem_req=0 and data_addr_ok=0. After one mem_data_ok -> next cycle mem_req=1.
5. Starvation: data_req held with mem_addr_ok=1 every cycle, inst_req held -> inst granted on the cycle starve_cnt reaches 8 (9th cycle of waiting); starve_cnt then clears.
6. Lock and reset: data granted, mem_addr_ok low for 3 cycles, inst_req arrives in cycle 1 -> mem_cmd stays data for all cycles. Then assert reset with 1 outstanding -> mem_req=0 and count=0. After reset, a stray mem_data_ok -> proto_err=1, no upstream data_ok.
